lsu_dmem: RTL and testbench
===========================

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 SHALL have parameter ADD_WIDTH, default 18; byte-address width decoded by the data memory, with the same meaning as in the data memory it drives.
REQ-002 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, the core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready at a clk edge.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1: zero-extend load data when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse per accepted request.
REQ-012 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_misalign, output, 1, error flag, qualified by resp_valid.
REQ-014 SHALL have port mem_add, output, 32, word-aligned address (bits 1:0 = 0).
REQ-015 SHALL have port mem_wen, output, 4, per-byte write enables.
REQ-016 SHALL have port mem_wdata, output, 32, lane-aligned store data.
REQ-017 SHALL have port mem_rdata, input, 32, registered read data, valid one cycle after mem_add.

Function
REQ-018 SHALL use FSM states IDLE and SPLIT; req_ready = 1 only in IDLE and never while reset is high.
REQ-019 SHALL, on an accepted single-beat request in cycle N, drive mem_add = addr & ~3 in cycle N and assert resp_valid in cycle N+1, sustaining one request per cycle.
REQ-020 SHALL drive stores as mem_wen = size mask << addr[1:0] and mem_wdata = req_wdata << (8*addr[1:0]); mem_wen SHALL be 0000 in every other cycle.
REQ-021 SHALL, for loads, register the size, unsigned flag and offset, then in cycle N+1 form resp_rdata = mem_rdata >> (8*offset), truncated to size and sign- or zero-extended.
REQ-022 SHALL keep resp_rdata and resp_misalign at 0 whenever resp_valid = 0.
REQ-023 SHALL treat req_size = 11 as an error regardless of configuration: no memory write, resp_valid at N+1, resp_misalign = 1.
REQ-024 SHALL ignore req_valid while reset is high.

Reset
REQ-025 SHALL, on reset, set state = IDLE, resp_valid = 0, resp_rdata = 0, resp_misalign = 0, mem_wen = 0000 and mem_add = 0.
REQ-026 SHALL, on reset asserted during SPLIT, abandon the request: the second beat is not issued (mem_wen = 0000), no response is given, and a completed first-beat write persists.

Configuration
REQ-027 SHALL be governed by macro LSU_MISALIGN_SPLIT_EN.
REQ-028 SHALL, with LSU_MISALIGN_SPLIT_EN defined, complete accesses within one word in a single beat (half at offset 1 included), and split accesses crossing a word boundary (half at offset 3; word at offset 1-3) as follows.
REQ-029 SHALL issue split beat 1 in cycle N at A & ~3, go to SPLIT, issue beat 2 in N+1 at (A & ~3) + 4, and assert resp_valid in N+2.
REQ-030 SHALL form split-load data from {beat2, beat1} >> (8*offset) and split-store enables/data from the 8-byte shifted mask and data.
REQ-031 SHALL, without LSU_MISALIGN_SPLIT_EN, treat a half at an odd address or a word at a non-zero offset as misaligned: no write, resp_valid at N+1 with resp_misalign = 1; SPLIT is unreachable.

Structure
REQ-032 SHALL place size encodings, the FSM state enum and byte-mask constants in shared package lsu_pkg.
REQ-033 SHALL use sub-module lsu_align: combinational lane shift, 64-to-32 extract and sign/zero extension, instantiated once for load and once for store.

Verification
Preset memory: 0x100 = 0x88776655, 0x104 = 0xCCBBAA99.
REQ-034 SHALL cover: lb 0x103 -> resp_rdata 0xFFFFFF88 at N+1; lbu 0x103 -> 0x00000088; lh 0x100 -> 0x00006655.
REQ-035 SHALL cover: sh 0xABCD at 0x102 -> mem_wen 1100, mem_wdata 0xABCD0000; then back-to-back sw 0xDEADBEEF at 0x108 and lw 0x108 -> mem_wen 1111, then 0xDEADBEEF, one response per cycle.
REQ-036 SHALL cover lw 0x102: with the macro, beats at 0x100 and 0x104 and resp_rdata 0xAA998877 at N+2; without it, resp_misalign = 1 at N+1 and mem_wen = 0000 throughout.
REQ-037 SHALL cover, with the macro, sw 0x11223344 at 0x103 -> beat 1 mem_wen 1000 with byte3 = 0x44, beat 2 at 0x104 mem_wen 0111 with low 24 bits 0x112233.
REQ-038 SHALL cover repeating the split store with reset high in N+1 -> beat 2 mem_wen 0000, no resp_valid, 0x104 unchanged, req_ready = 1 after reset.
REQ-039 SHALL cover req_size = 11 at 0x100 -> resp_misalign = 1 and memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, the
// sequencer states and the per-size byte-enable masks.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_e;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   // Right-justified byte enables for an access size; reserved size writes nothing.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_mask = MASK_BYTE;
         SZ_HALF: size_mask = MASK_HALF;
         SZ_WORD: size_mask = MASK_WORD;
         default: size_mask = MASK_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane aligner: shifts a 64-bit lane pair up by the byte offset (store
// path) and down by the byte offset with 32-bit extract and sign/zero
// extension (load path). Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [63:0] i_data,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [63:0] o_lanes,
   output logic [31:0] o_ext
);

   logic [4:0]  w_sh;
   logic [31:0] w_down;
   logic        w_sgn_b;
   logic        w_sgn_h;

   assign w_sh    = {i_off, 3'b000};
   assign o_lanes = i_data << w_sh;
   assign w_down  = 32'(i_data >> w_sh);
   assign w_sgn_b = ~i_unsigned & w_down[7];
   assign w_sgn_h = ~i_unsigned & w_down[15];

   // Truncate the extracted word to the access size and extend it.
   always_comb begin
      o_ext = '0;
      case (size_e'(i_size))
         SZ_BYTE: o_ext = {{24{w_sgn_b}}, w_down[7:0]};
         SZ_HALF: o_ext = {{16{w_sgn_h}}, w_down[15:0]};
         SZ_WORD: o_ext = w_down;
         default: o_ext = '0;
      endcase
   end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit in front of a word-wide data memory with registered reads.
// Single-beat accesses respond one cycle after acceptance. Optional feature
// macro LSU_MISALIGN_SPLIT_EN: word-crossing accesses are split into two
// beats and respond two cycles after acceptance; without it they are flagged
// misaligned.
//
//   state | meaning
//   IDLE  | ready for a request; single-beat access or split beat 1 issued here
//   SPLIT | second beat of a word-crossing access on the memory port
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int ADD_WIDTH = 18
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misalign,
   output logic [31:0] mem_add,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // The memory decodes only the low ADD_WIDTH bits; the full word address is
   // forwarded so that mem_add matches the core's view of the access.
   localparam int ADD_WIDTH_UNUSED = ADD_WIDTH;

   state_e      r_state;
   state_e      w_state_nxt;

   logic        w_ready;
   logic        w_acc;
   logic        w_rsvd;
   logic        w_bad;
   logic        w_cross;
   logic [1:0]  w_off;
   logic [7:0]  w_wen8;
   logic [63:0] w_st_lanes;
   logic [31:0] w_st_ext_unused;
   logic [63:0] w_ld_in;
   logic [63:0] w_ld_lanes_unused;
   logic [31:0] w_ld_ext;

   logic        r_resp_valid;
   logic        r_misalign;
   logic        r_load;
   logic        r_split;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_off;
   logic [31:0] r_beat1;
   logic [31:0] r_split_add;
   logic [3:0]  r_split_wen;
   logic [31:0] r_split_wdata;

   assign w_off     = req_addr[1:0];
   assign w_ready   = (r_state == IDLE) && !reset;
   assign req_ready = w_ready;
   assign w_acc     = req_valid && w_ready;
   assign w_rsvd    = (req_size == SZ_RSVD);
   assign w_wen8    = {4'b0000, size_mask(req_size)} << w_off;

`ifdef LSU_MISALIGN_SPLIT_EN
   assign w_bad   = w_rsvd;
   assign w_cross = ((req_size == SZ_HALF) && (w_off == 2'd3)) ||
                    ((req_size == SZ_WORD) && (w_off != 2'd0));
`else
   assign w_bad   = w_rsvd ||
                    ((req_size == SZ_HALF) && w_off[0]) ||
                    ((req_size == SZ_WORD) && (w_off != 2'd0));
   assign w_cross = 1'b0;
`endif

   lsu_align u_st_align (
      .i_data     ({32'h0000_0000, req_wdata}),
      .i_off      (w_off),
      .i_size     (req_size),
      .i_unsigned (1'b0),
      .o_lanes    (w_st_lanes),
      .o_ext      (w_st_ext_unused)
   );

   // A split load sees beat 2 on the memory bus and beat 1 in r_beat1.
   assign w_ld_in = r_split ? {mem_rdata, r_beat1} : {32'h0000_0000, mem_rdata};

   lsu_align u_ld_align (
      .i_data     (w_ld_in),
      .i_off      (r_off),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_lanes    (w_ld_lanes_unused),
      .o_ext      (w_ld_ext)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and memory-port drive; the port is idle (all zero) unless a beat is issued.
   always_comb begin
      w_state_nxt = r_state;
      mem_add     = '0;
      mem_wen     = '0;
      mem_wdata   = '0;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               mem_add = {req_addr[31:2], 2'b00};
               if (req_we && !w_bad) begin
                  mem_wen   = w_wen8[3:0];
                  mem_wdata = w_st_lanes[31:0];
               end
               if (w_cross) w_state_nxt = SPLIT;
            end
         end
         SPLIT: begin
            w_state_nxt = IDLE;
            // Reset during the second beat abandons it.
            if (!reset) begin
               mem_add   = r_split_add;
               mem_wen   = r_split_wen;
               mem_wdata = r_split_wdata;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture request attributes on acceptance and schedule the response pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_valid  <= 1'b0;
         r_misalign    <= 1'b0;
         r_load        <= 1'b0;
         r_split       <= 1'b0;
         r_size        <= 2'b00;
         r_unsigned    <= 1'b0;
         r_off         <= 2'b00;
         r_beat1       <= '0;
         r_split_add   <= '0;
         r_split_wen   <= '0;
         r_split_wdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_misalign   <= 1'b0;
         if (r_state == SPLIT) begin
            r_resp_valid <= 1'b1;
            r_beat1      <= mem_rdata;
         end else if (w_acc) begin
            r_resp_valid  <= !w_cross;
            r_misalign    <= w_bad;
            r_load        <= !req_we && !w_bad;
            r_split       <= w_cross;
            r_size        <= req_size;
            r_unsigned    <= req_unsigned;
            r_off         <= w_off;
            r_split_add   <= {req_addr[31:2], 2'b00} + 32'd4;
            r_split_wen   <= req_we ? w_wen8[7:4] : 4'b0000;
            r_split_wdata <= w_st_lanes[63:32];
         end
      end
   end

   assign resp_valid    = r_resp_valid;
   assign resp_misalign = r_resp_valid && r_misalign;
   assign resp_rdata    = (r_resp_valid && r_load) ? w_ld_ext : '0;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: a registered-read word memory on the memory port, a
// byte-level reference of the access rules, directed cases and random traffic.
// Build with or without LSU_MISALIGN_SPLIT_EN.
module tb_lsu_dmem;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [31:0] mem_add;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   lsu_dmem dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_misalign (resp_misalign),
      .mem_add       (mem_add),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   // ---------------- memory (1 KiB, registered read) ----------------
   logic [31:0] mem [0:255];

   function automatic logic [31:0] init_word(input int i);
      if (i == 64)      init_word = 32'h8877_6655;
      else if (i == 65) init_word = 32'hCCBB_AA99;
      else              init_word = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         mem_rdata <= mem[mem_add[9:2]];
         for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mem[mem_add[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
   end

   // ---------------- reference model (byte array) ----------------
   logic [7:0]  ref_b [0:1023];
   logic        e_err;
   int          e_lat;
   logic [31:0] e_rd;

   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'b00:   nbytes = 1;
         2'b01:   nbytes = 2;
         2'b10:   nbytes = 4;
         default: nbytes = 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input int w);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_b[4*w + k];
      return v;
   endfunction

   task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      int n;
      int off;
      logic [31:0] v;
      n   = nbytes(sz);
      off = int'(a[1:0]);
      if (n == 0)                              e_err = 1'b1;
      else if (!SPLIT_EN && (off % n) != 0)    e_err = 1'b1;
      else                                     e_err = 1'b0;
      e_lat = (!e_err && SPLIT_EN && (off + n > 4)) ? 2 : 1;
      e_rd  = '0;
      if (!e_err && !we) begin
         v = '0;
         for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[int'(a) + k];
         if (!uns && n < 4 && v[8*n-1])
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
         e_rd = v;
      end
      if (!e_err && we)
         for (int k = 0; k < n; k++) ref_b[int'(a) + k] = wd[8*k +: 8];
   endtask

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Observations of one isolated transaction.
   logic        c_ready, c_rv0, c_mis;
   logic [31:0] c_rd0, c_rd, c_add1, c_add2, c_wd1, c_wd2;
   logic [3:0]  c_wen1, c_wen2;
   int          lat;

   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      c_ready = req_ready; c_rv0 = resp_valid; c_rd0 = resp_rdata;
      c_add1 = mem_add; c_wen1 = mem_wen; c_wd1 = mem_wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      lat = 0; c_mis = 1'b0; c_rd = '0;
      c_add2 = '0; c_wen2 = '0; c_wd2 = '0;
      for (int i = 1; i <= 3 && lat == 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            c_add2 = mem_add; c_wen2 = mem_wen; c_wd2 = mem_wdata;
         end
         if (resp_valid) begin
            lat = i; c_mis = resp_misalign; c_rd = resp_rdata;
         end
      end
   endtask

   task automatic run(input string tag, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
      model(we, sz, uns, a, wd);
      xact(we, sz, uns, a, wd);
      chk({tag, "_ready"},   {31'b0, c_ready}, 32'd1);
      chk({tag, "_idle_rv"}, {31'b0, c_rv0},   32'd0);
      chk({tag, "_idle_rd"}, c_rd0,            32'd0);
      chk({tag, "_add1"},    c_add1,           a & ~32'd3);
      chk({tag, "_lat"},     lat,              e_lat);
      chk({tag, "_mis"},     {31'b0, c_mis},   {31'b0, e_err});
      chk({tag, "_rdata"},   c_rd,             e_rd);
      if (e_err || !we) chk({tag, "_wen1"}, {28'b0, c_wen1}, 32'd0);
      if (e_lat == 2)   chk({tag, "_add2"}, c_add2, (a & ~32'd3) + 32'd4);
      else              chk({tag, "_wen2"}, {28'b0, c_wen2}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bad;
      logic        r_we, r_uns;
      logic [1:0]  r_sz;
      logic [31:0] r_a, r_wd;

      for (int i = 0; i < 256; i++)
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = init_word(i) >> (8*k);

      // Reset with a request pending: nothing may be accepted or issued.
      reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h1234_5678;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready},     32'd0);
      chk("rst_wen",   {28'b0, mem_wen},       32'd0);
      chk("rst_add",   mem_add,                32'd0);
      chk("rst_rv",    {31'b0, resp_valid},    32'd0);
      chk("rst_rdata", resp_rdata,             32'd0);
      chk("rst_mis",   {31'b0, resp_misalign}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      chk("post_rst_rv",    {31'b0, resp_valid}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready},  32'd1);

      // Directed loads on the preset words.
      run("lb_103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      chk("lb_103_val", c_rd, 32'hFFFF_FF88);
      run("lbu_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
      chk("lbu_103_val", c_rd, 32'h0000_0088);
      run("lh_100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
      chk("lh_100_val", c_rd, 32'h0000_6655);

      run("lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("lw_102_val",  c_rd,   32'hAA99_8877);
      chk("lw_102_lat",  lat,    32'd2);
      chk("lw_102_add2", c_add2, 32'h104);
`else
      chk("lw_102_mis",  {31'b0, c_mis}, 32'd1);
      chk("lw_102_wen2", {28'b0, c_wen2}, 32'd0);
`endif

      run("sh_102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD);
      chk("sh_102_wen", {28'b0, c_wen1}, 32'b1100);
      chk("sh_102_wd",  c_wd1,           32'hABCD_0000);

      // Back-to-back store then load of the same word.
      model(1'b1, 2'b10, 1'b0, 32'h108, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h108; req_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("b2b_sw_wen", {28'b0, mem_wen}, 32'b1111);
      chk("b2b_sw_wd",  mem_wdata,        32'hDEAD_BEEF);
      @(posedge clk); #1;
      req_we = 1'b0;
      model(1'b0, 2'b10, 1'b0, 32'h108, 32'h0);
      @(negedge clk);
      chk("b2b_sw_rv",    {31'b0, resp_valid}, 32'd1);
      chk("b2b_sw_rdata", resp_rdata,          32'd0);
      chk("b2b_lw_ready", {31'b0, req_ready},  32'd1);
      chk("b2b_lw_wen",   {28'b0, mem_wen},    32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_lw_rv",    {31'b0, resp_valid}, 32'd1);
      chk("b2b_lw_rdata", resp_rdata,          e_rd);
      chk("b2b_lw_val",   resp_rdata,          32'hDEAD_BEEF);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Split store across 0x100/0x104.
      run("sw_103", 1'b1, 2'b10, 1'b0, 32'h103, 32'h1122_3344);
      chk("sw_103_wen1", {28'b0, c_wen1}, 32'b1000);
      chk("sw_103_b3",   {24'b0, c_wd1[31:24]}, 32'h44);
      chk("sw_103_add2", c_add2, 32'h104);
      chk("sw_103_wen2", {28'b0, c_wen2}, 32'b0111);
      chk("sw_103_lo24", {8'b0, c_wd2[23:0]}, 32'h0011_2233);

      // Same split store, reset during the second beat.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h103; req_wdata = 32'h5566_7788;
      @(negedge clk);
      chk("rsplit_wen1", {28'b0, mem_wen}, 32'b1000);
      @(posedge clk); #1;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      ref_b[32'h103] = 8'h88;
      @(negedge clk);
      chk("rsplit_wen2",  {28'b0, mem_wen},   32'd0);
      chk("rsplit_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rsplit_rv",     {31'b0, resp_valid}, 32'd0);
      chk("rsplit_ready2", {31'b0, req_ready},  32'd1);
      chk("rsplit_mem104", mem[65], 32'hCC11_2233);
      chk("rsplit_mem100", mem[64], ref_word(64));
`endif

      // Reserved size.
      run("rsvd_100", 1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFF_FFFF);
      chk("rsvd_mis", {31'b0, c_mis}, 32'd1);
      chk("rsvd_mem", mem[64], ref_word(64));

      // Random traffic against the reference model.
      for (int t = 0; t < 200; t++) begin
         r_we  = 1'($urandom_range(0, 1));
         r_sz  = 2'($urandom_range(0, 3));
         r_uns = 1'($urandom_range(0, 1));
         r_a   = $urandom_range(0, 32'h3F0);
         r_wd  = $urandom;
         run("rnd", r_we, r_sz, r_uns, r_a, r_wd);
      end

      bad = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_word(i)) bad++;
      chk("mem_image", bad, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
